// File: rtl/collatz_start_ctrl_if.sv
// collatz_start_ctrl_if: bundle of key, switch, engine-handshake and display
// signals around the Collatz start controller.
// master: the controller side. slave: the board and range-engine side.
`timescale 1ns/1ps
interface collatz_start_ctrl_if #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 16
);
  logic [3:0]          key_n;
  logic [N_BITS-1:0]   sw;
  logic                done;
  logic [CNT_BITS-1:0] count_in;
  logic [N_BITS-1:0]   start;
  logic                go;
  logic                busy;
  logic [CNT_BITS-1:0] count_out;
  logic                valid;

  modport master (
    input  key_n, sw, done, count_in,
    output start, go, busy, count_out, valid
  );

  modport slave (
    output key_n, sw, done, count_in,
    input  start, go, busy, count_out, valid
  );
endinterface

// File: rtl/collatz_start_ctrl.sv
// collatz_start_ctrl: pushbutton front end and run controller for the Collatz
// range engine. Debounces four active-low keys, edits the start value
// (inc/dec with auto-repeat, load from switches), launches the engine with a
// one-cycle go and latches the returned iteration count.
// Optional macro COLLATZ_START_CTRL_WRAP_EN: inc/dec wrap around at the
// range ends instead of saturating.
`timescale 1ns/1ps
module collatz_start_ctrl #(
  parameter int N_BITS          = 8,
  parameter int MAX_VAL         = 255,
  parameter int CNT_BITS        = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input logic                  clk,
  input logic                  reset,
  collatz_start_ctrl_if.master bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [N_BITS-1:0] MAX_N = N_BITS'(MAX_VAL);

`ifdef COLLATZ_START_CTRL_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  // One-cycle press events: [0] inc, [1] dec, [2] load, [3] go
  logic [3:0] key_ev;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    // Levels are stored as "pressed" (inverted key_n), so reset = released.
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic            ev_q, ev_d;
    logic            rep_fire;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Synchroniser, debounce state and event register
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        ev_q    <= 1'b0;
      end else begin
        sync1_q <= ~bus.key_n[gi];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        ev_q    <= ev_d;
      end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
    // an event is the press edge or an auto-repeat tick while still pressed
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ev_d = deb_d & (~deb_q | rep_fire);
    end

    if (gi < 2) begin : g_rep
      logic [RP_W-1:0] rep_q, rep_d;
      logic            fire;

      // Hold-time counter: first tick at REPEAT_DELAY, then every REPEAT_RATE
      always_comb begin
        rep_d = '0;
        fire  = 1'b0;
        if (deb_q) begin
          rep_d = rep_q + 1'b1;
          if (rep_d == RP_W'(REPEAT_DELAY)) begin
            fire = 1'b1;
          end else if (rep_d == RP_W'(REPEAT_DELAY + REPEAT_RATE)) begin
            fire  = 1'b1;
            rep_d = RP_W'(REPEAT_DELAY);
          end
        end
      end

      // Hold-time counter register
      always_ff @(posedge clk) begin
        if (reset) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_d;
        end
      end

      assign rep_fire = fire;
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end

    assign key_ev[gi] = ev_q;
  end

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   start_q, start_d;
  logic [N_BITS-1:0]   edit_val, inc_val, dec_val;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                valid_q, valid_d;

  // Run FSM, start-value edits and result latch
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    count_d  = count_q;
    valid_d  = valid_q;
    inc_val  = (start_q >= MAX_N) ? (WRAP ? '0 : MAX_N) : start_q + 1'b1;
    dec_val  = (start_q == '0) ? (WRAP ? MAX_N : '0) : start_q - 1'b1;
    edit_val = start_q;
    case (state_q)
      S_IDLE: begin
        if (key_ev[2]) begin
          edit_val = (bus.sw > MAX_N) ? MAX_N : bus.sw;
        end else if (key_ev[0] && !key_ev[1]) begin
          edit_val = inc_val;
        end else if (key_ev[1] && !key_ev[0]) begin
          edit_val = dec_val;
        end
        // Only an edit that actually moves start invalidates the result
        if (edit_val != start_q) begin
          start_d = edit_val;
          valid_d = 1'b0;
        end
        if (key_ev[3]) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done) begin
          count_d = bus.count_in;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.go        = (state_q == S_LAUNCH);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.count_out = count_q;
  assign bus.valid     = valid_q;
endmodule

// File: tb/tb_collatz_start_ctrl.sv
// tb_collatz_start_ctrl: directed bench for collatz_start_ctrl with a
// behavioural reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_collatz_start_ctrl;
  localparam int N_BITS   = 8;
  localparam int MAX_VAL  = 255;
  localparam int CNT_BITS = 16;
  localparam int DB       = 4;
  localparam int RD       = 20;
  localparam int RR       = 5;
  localparam int HIST     = 8192;

`ifdef COLLATZ_START_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  collatz_start_ctrl_if #(.N_BITS(N_BITS), .CNT_BITS(CNT_BITS)) bus ();

  collatz_start_ctrl #(
    .N_BITS(N_BITS), .MAX_VAL(MAX_VAL), .CNT_BITS(CNT_BITS),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] samp [HIST];
  int         edge_n   = -1;
  int         last_rst = -1;
  logic       m_live   = 1'b0;
  int         m_start  = 0;
  int         m_count  = 0;
  int         m_phase  = 0;   // 0 idle, 1 launch cycle, 2 waiting for done
  logic       m_valid  = 1'b0;
  logic [3:0] m_deb    = 4'b0;
  logic [3:0] pend     = 4'b0;
  int         m_press [4];

  always @(posedge clk) begin
    int   nv;
    int   held;
    bit   all_diff;
    bit   s;
    edge_n++;
    samp[edge_n % HIST] = ~bus.key_n;
    if (reset) begin
      m_live   = 1'b1;
      last_rst = edge_n;
      m_start  = 0;
      m_count  = 0;
      m_phase  = 0;
      m_valid  = 1'b0;
      m_deb    = 4'b0;
      pend     = 4'b0;
    end else begin
      // Apply the events that were pending during the cycle just ended
      case (m_phase)
        0: begin
          nv = m_start;
          if (pend[2]) nv = (int'(bus.sw) > MAX_VAL) ? MAX_VAL : int'(bus.sw);
          else if (pend[0] && !pend[1]) nv = (m_start >= MAX_VAL) ? (WRAP ? 0 : MAX_VAL) : m_start + 1;
          else if (pend[1] && !pend[0]) nv = (m_start == 0) ? (WRAP ? MAX_VAL : 0) : m_start - 1;
          if (nv != m_start) begin
            m_start = nv;
            m_valid = 1'b0;
          end
          if (pend[3]) m_phase = 1;
        end
        1: m_phase = 2;
        default: begin
          if (bus.done) begin
            m_count = int'(bus.count_in);
            m_valid = 1'b1;
            m_phase = 0;
          end
        end
      endcase
      // A key level counts once it has been seen DB samples in a row,
      // two synchroniser stages after the pin
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int i = edge_n - DB - 1; i <= edge_n - 2; i++) begin
          s = (i <= last_rst) ? 1'b0 : samp[i % HIST][k];
          if (s == m_deb[k]) all_diff = 1'b0;
        end
        pend[k] = 1'b0;
        if (all_diff) begin
          m_deb[k] = ~m_deb[k];
          if (m_deb[k]) begin
            m_press[k] = edge_n;
            pend[k]    = 1'b1;
          end
        end else if (m_deb[k] && k < 2) begin
          held = edge_n - m_press[k];
          if (held >= RD && ((held - RD) % RR) == 0) pend[k] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("start",     32'(bus.start),     32'(m_start));
      check("go",        32'(bus.go),        32'(m_phase == 1));
      check("busy",      32'(bus.busy),      32'(m_phase != 0));
      check("count_out", 32'(bus.count_out), 32'(m_count));
      check("valid",     32'(bus.valid),     32'(m_valid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold);
    bus.key_n[k] = 1'b0;
    tick(hold);
    bus.key_n[k] = 1'b1;
    tick(DB + 4);
  endtask

  // Press the go key and act as the range engine; offsets are relative to go
  task automatic run_go(input int done_dly, input logic [15:0] cval, input int go_hold,
                        input int poke_at, input int rst_at,
                        output int go_n, output int busy_n);
    int go_at;
    go_at  = -1;
    go_n   = 0;
    busy_n = 0;
    bus.key_n[3] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == go_hold) bus.key_n[3] = 1'b1;
      if (bus.go === 1'b1) begin
        go_n++;
        if (go_at < 0) go_at = c;
      end
      if (bus.busy === 1'b1) busy_n++;
      bus.done     = 1'b0;
      bus.count_in = 16'hBEEF;
      if (go_at >= 0) begin
        if (c == go_at + done_dly) begin
          bus.done     = 1'b1;
          bus.count_in = cval;
        end
        if (poke_at >= 0 && c == go_at + poke_at) begin
          bus.key_n[0] = 1'b0;
          bus.key_n[3] = 1'b0;
        end
        if (poke_at >= 0 && c == go_at + poke_at + 10) begin
          bus.key_n[0] = 1'b1;
          bus.key_n[3] = 1'b1;
        end
        if (rst_at >= 0 && c == go_at + rst_at) reset = 1'b1;
        if (rst_at >= 0 && c == go_at + rst_at + 2) reset = 1'b0;
      end
    end
    bus.done = 1'b0;
    $display("run: go_pulses=%0d busy_cycles=%0d start=%0d count_out=%0d valid=%0d",
             go_n, busy_n, bus.start, bus.count_out, bus.valid);
  endtask

  initial begin
    int go_n;
    int busy_n;
    bus.key_n    = 4'hF;
    bus.sw       = '0;
    bus.done     = 1'b0;
    bus.count_in = '0;
    reset        = 1'b1;
    tick(3);
    check("rst_start", 32'(bus.start), 0);
    check("rst_go", 32'(bus.go), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.count_out), 0);
    check("rst_valid", 32'(bus.valid), 0);
    reset = 1'b0;
    tick(2);

    // Bounces are filtered; 30-cycle hold gives the press plus two repeats
    for (int b = 0; b < 3; b++) begin
      bus.key_n[0] = 1'b0;
      tick(1);
      bus.key_n[0] = 1'b1;
      tick(1);
    end
    bus.key_n[0] = 1'b0;
    tick(30);
    bus.key_n[0] = 1'b1;
    tick(DB + 4);
    $display("hold inc: start=%0d", bus.start);
    check("hold_repeat_start", 32'(bus.start), 3);

    // Load 200, then 60 increments run into the top of the range
    bus.sw = 8'd200;
    press(2, 6);
    check("load_200", 32'(bus.start), 200);
    for (int i = 0; i < 60; i++) begin
      press(0, 6);
      if (i == 54) check("inc_55_top", 32'(bus.start), 255);
      if (i == 55) check("inc_56_edge", 32'(bus.start), WRAP ? 0 : 255);
    end
    $display("inc x60: start=%0d", bus.start);
    check("inc_60_final", 32'(bus.start), WRAP ? 4 : 255);

    bus.sw = 8'd27;
    press(2, 6);
    check("load_27", 32'(bus.start), 27);
    check("load_27_valid", 32'(bus.valid), 0);

    // Launch with the go key held past the repeat delay: exactly one go
    run_go(10, 16'd111, 30, -1, -1, go_n, busy_n);
    check("run1_go_pulses", 32'(go_n), 1);
    check("run1_busy_cycles", 32'(busy_n), 11);
    check("run1_count_out", 32'(bus.count_out), 111);
    check("run1_valid", 32'(bus.valid), 1);
    check("run1_start", 32'(bus.start), 27);

    // inc and go presses while waiting are discarded
    run_go(40, 16'd111, 8, 15, -1, go_n, busy_n);
    check("run2_go_pulses", 32'(go_n), 1);
    check("run2_start", 32'(bus.start), 27);
    check("run2_valid", 32'(bus.valid), 1);

    // Load of an identical value keeps the result valid
    press(2, 6);
    check("reload_same_valid", 32'(bus.valid), 1);

    press(1, 6);
    $display("dec: start=%0d valid=%0d count_out=%0d", bus.start, bus.valid, bus.count_out);
    check("dec_start", 32'(bus.start), 26);
    check("dec_valid", 32'(bus.valid), 0);
    check("dec_count_kept", 32'(bus.count_out), 111);

    // done while idle is ignored
    bus.done     = 1'b1;
    bus.count_in = 16'd999;
    tick(1);
    bus.done     = 1'b0;
    bus.count_in = '0;
    tick(2);
    $display("idle done: count_out=%0d valid=%0d", bus.count_out, bus.valid);
    check("idle_done_count", 32'(bus.count_out), 111);
    check("idle_done_valid", 32'(bus.valid), 0);

    // Reset three cycles into the wait, then a late done
    run_go(8, 16'd77, 8, -1, 3, go_n, busy_n);
    check("rst_run_go_pulses", 32'(go_n), 1);
    check("rst_run_start", 32'(bus.start), 0);
    check("rst_run_busy", 32'(bus.busy), 0);
    check("rst_run_count", 32'(bus.count_out), 0);
    check("rst_run_valid", 32'(bus.valid), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
